// File: rtl/amber48_run_ctrl.sv
// Run controller for amber48: sequences core reset, gates clk_en, counts cycles/retires, halts on trap/stop/timeout.
// Optional stall watchdog enabled by defining AMBER48_RUN_CTRL_STALL_WDT_EN.
module amber48_run_ctrl #(
  parameter int RST_CYCLES   = 4,
  parameter int TMO_W        = 16,
  parameter int CNT_W        = 32,
  parameter int STALL_CYCLES = 256
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [TMO_W-1:0] timeout_i,
  input  logic             trap_i,
  input  logic [2:0]       trap_cause_i,
  input  logic             retired_i,
  output logic             core_rst_no,
  output logic             core_clk_en_o,
  output logic [1:0]       state_o,
  output logic             done_o,
  output logic [2:0]       status_o,
  output logic [2:0]       cause_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] retire_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e            state_q, state_d;
  logic [RC_W-1:0]   rcnt_q, rcnt_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [CNT_W-1:0]  ret_q, ret_d;
  logic [2:0]        status_q, status_d;
  logic [2:0]        cause_q, cause_d;
  logic [CNT_W-1:0]  tmo_ext;
  logic              tmo_hit;
  logic              stall_hit;
  logic              start_ok;

  // Timeout is compared against the low CNT_W bits only.
  generate
    if (TMO_W > CNT_W) begin : g_tmo_trunc
      logic unused_tmo_hi;
      assign unused_tmo_hi = ^timeout_i[TMO_W-1:CNT_W];
      assign tmo_ext = timeout_i[CNT_W-1:0];
    end else if (TMO_W == CNT_W) begin : g_tmo_same
      assign tmo_ext = timeout_i;
    end else begin : g_tmo_ext
      assign tmo_ext = {{(CNT_W-TMO_W){1'b0}}, timeout_i};
    end
  endgenerate

  // Widened compare: a zero limit never matches, and a saturated counter cannot alias.
  assign tmo_hit  = (({1'b0, cyc_q} + (CNT_W+1)'(1)) == {1'b0, tmo_ext});
  assign start_ok = start_i && (state_q == S_IDLE || state_q == S_HALT);

`ifdef AMBER48_RUN_CTRL_STALL_WDT_EN
  localparam int ST_W = $clog2(STALL_CYCLES + 1);
  logic [ST_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d   = stall_q;
    stall_hit = 1'b0;
    if (start_ok) begin
      stall_d = '0;
    end else if (state_q == S_RUN) begin
      if (retired_i) begin
        stall_d = '0;
      end else begin
        stall_d   = stall_q + 1'b1;
        stall_hit = (stall_d == ST_W'(STALL_CYCLES));
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stall_q <= '0;
    else       stall_q <= stall_d;
  end
`else
  localparam int unused_stall_cycles = STALL_CYCLES;
  assign stall_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q;
    cyc_d    = cyc_q;
    ret_d    = ret_q;
    status_d = status_q;
    cause_d  = cause_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start_ok) begin
          state_d  = S_RESET;
          rcnt_d   = '0;
          cyc_d    = '0;
          ret_d    = '0;
          status_d = 3'd0;
          cause_d  = 3'd0;
        end
      end
      S_RESET: begin
        if (stop_i) begin
          state_d  = S_HALT;
          status_d = 3'd3;
        end else if (rcnt_q == RC_W'(RST_CYCLES - 1)) begin
          state_d = S_RUN;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (cyc_q != CNT_MAX) cyc_d = cyc_q + 1'b1;
        if (retired_i && ret_q != CNT_MAX) ret_d = ret_q + 1'b1;
        if (trap_i) begin
          state_d  = S_HALT;
          status_d = 3'd1;
          cause_d  = trap_cause_i;
        end else if (stop_i) begin
          state_d  = S_HALT;
          status_d = 3'd3;
        end else if (tmo_hit) begin
          state_d  = S_HALT;
          status_d = 3'd2;
        end else if (stall_hit) begin
          state_d  = S_HALT;
          status_d = 3'd4;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      rcnt_q   <= '0;
      cyc_q    <= '0;
      ret_q    <= '0;
      status_q <= 3'd0;
      cause_q  <= 3'd0;
    end else begin
      state_q  <= state_d;
      rcnt_q   <= rcnt_d;
      cyc_q    <= cyc_d;
      ret_q    <= ret_d;
      status_q <= status_d;
      cause_q  <= cause_d;
    end
  end

  assign state_o       = state_q;
  assign core_rst_no   = (state_q == S_RUN) || (state_q == S_HALT);
  assign core_clk_en_o = (state_q == S_RESET) || (state_q == S_RUN);
  assign done_o        = (state_q == S_HALT);
  assign status_o      = status_q;
  assign cause_o       = cause_q;
  assign cycle_cnt_o   = cyc_q;
  assign retire_cnt_o  = ret_q;

endmodule

// File: tb/tb_amber48_run_ctrl.sv
// Self-checking bench for amber48_run_ctrl: directed vector table, corner sequences and randomized run against a reference model.
module tb_amber48_run_ctrl;
  localparam int CW    = 12;
  localparam int MAXC  = 4095;
  localparam int RSTC  = 4;
  localparam int STALL = 8;
`ifdef AMBER48_RUN_CTRL_STALL_WDT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, stop, trap, retired;
  logic [2:0]    tcause;
  logic [15:0]   tmo;
  logic          core_rst_n, clk_en, done;
  logic [1:0]    state;
  logic [2:0]    status, cause;
  logic [CW-1:0] cyc, ret;

  amber48_run_ctrl #(
    .RST_CYCLES(RSTC), .TMO_W(16), .CNT_W(CW), .STALL_CYCLES(STALL)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
    .timeout_i(tmo), .trap_i(trap), .trap_cause_i(tcause), .retired_i(retired),
    .core_rst_no(core_rst_n), .core_clk_en_o(clk_en), .state_o(state),
    .done_o(done), .status_o(status), .cause_o(cause),
    .cycle_cnt_o(cyc), .retire_cnt_o(ret)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: phase 0 idle, 1 reset, 2 run, 3 halt.
  int m_state, m_rcnt, m_cyc, m_ret, m_status, m_cause, m_stall;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_rcnt = 0; m_cyc = 0; m_ret = 0;
    m_status = 0; m_cause = 0; m_stall = 0;
  endtask

  task automatic model_begin_run();
    m_state = 1; m_rcnt = 0; m_cyc = 0; m_ret = 0;
    m_status = 0; m_cause = 0; m_stall = 0;
  endtask

  task automatic model_step();
    int old_cyc;
    int limit;
    old_cyc = m_cyc;
    limit   = int'(tmo) % (MAXC + 1);
    case (m_state)
      0, 3: if (start) model_begin_run();
      1: begin
        if (stop) begin
          m_state = 3; m_status = 3;
        end else begin
          m_rcnt++;
          if (m_rcnt == RSTC) m_state = 2;
        end
      end
      default: begin
        m_cyc   = (m_cyc < MAXC) ? m_cyc + 1 : MAXC;
        if (retired) m_ret = (m_ret < MAXC) ? m_ret + 1 : MAXC;
        m_stall = retired ? 0 : m_stall + 1;
        if (trap) begin
          m_state = 3; m_status = 1; m_cause = int'(tcause);
        end else if (stop) begin
          m_state = 3; m_status = 3;
        end else if (limit != 0 && old_cyc + 1 == limit) begin
          m_state = 3; m_status = 2;
        end else if (STALL_EN && m_stall >= STALL) begin
          m_state = 3; m_status = 4;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    chk("state",     64'(state),      64'(m_state));
    chk("core_rst_n",64'(core_rst_n), (m_state >= 2) ? 64'd1 : 64'd0);
    chk("clk_en",    64'(clk_en),     (m_state == 1 || m_state == 2) ? 64'd1 : 64'd0);
    chk("done",      64'(done),       (m_state == 3) ? 64'd1 : 64'd0);
    chk("status",    64'(status),     64'(m_status));
    chk("cause",     64'(cause),      64'(m_cause));
    chk("cycle_cnt", 64'(cyc),        64'(m_cyc));
    chk("retire_cnt",64'(ret),        64'(m_ret));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic clear_in();
    start = 0; stop = 0; trap = 0; tcause = 0; retired = 0;
  endtask

  typedef struct {
    bit       start, stop, trap;
    bit [2:0] cause;
    bit       ret;
    int       st, rn, en, status, cause_e, cyc, rt;
  } vec_t;

  vec_t vt[11];

  initial begin
    // start stop trap cause ret | state rst_n en status cause cyc ret
    vt[0]  = '{0, 1, 0, 3'd0, 0,  0, 0, 0, 0, 0, 0, 0};
    vt[1]  = '{1, 0, 0, 3'd0, 0,  1, 0, 1, 0, 0, 0, 0};
    vt[2]  = '{0, 0, 0, 3'd0, 0,  1, 0, 1, 0, 0, 0, 0};
    vt[3]  = '{0, 0, 1, 3'd2, 1,  1, 0, 1, 0, 0, 0, 0};
    vt[4]  = '{0, 0, 0, 3'd0, 0,  1, 0, 1, 0, 0, 0, 0};
    vt[5]  = '{0, 0, 0, 3'd0, 0,  2, 1, 1, 0, 0, 0, 0};
    vt[6]  = '{1, 0, 0, 3'd0, 1,  2, 1, 1, 0, 0, 1, 1};
    vt[7]  = '{0, 1, 1, 3'd5, 1,  3, 1, 0, 1, 5, 2, 2};
    vt[8]  = '{0, 1, 0, 3'd0, 0,  3, 1, 0, 1, 5, 2, 2};
    vt[9]  = '{0, 0, 1, 3'd3, 1,  3, 1, 0, 1, 5, 2, 2};
    vt[10] = '{1, 0, 0, 3'd0, 0,  1, 0, 1, 0, 0, 0, 0};

    rst = 1; tmo = 0; clear_in();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst = 0;

    for (int i = 0; i < 11; i++) begin
      start = vt[i].start; stop = vt[i].stop; trap = vt[i].trap;
      tcause = vt[i].cause; retired = vt[i].ret;
      model_step();
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.state", i),  64'(state),      64'(vt[i].st));
      chk($sformatf("vec%0d.rst_n", i),  64'(core_rst_n), 64'(vt[i].rn));
      chk($sformatf("vec%0d.clk_en", i), 64'(clk_en),     64'(vt[i].en));
      chk($sformatf("vec%0d.status", i), 64'(status),     64'(vt[i].status));
      chk($sformatf("vec%0d.cause", i),  64'(cause),      64'(vt[i].cause_e));
      chk($sformatf("vec%0d.cyc", i),    64'(cyc),        64'(vt[i].cyc));
      chk($sformatf("vec%0d.ret", i),    64'(ret),        64'(vt[i].rt));
    end
    clear_in();

    // Stop during RESET, then restart repeats the reset sequence.
    stop = 1; step(); stop = 0;
    chk("rststop.status", 64'(status), 64'd3);
    chk("rststop.cyc",    64'(cyc),    64'd0);
    chk("rststop.done",   64'(done),   64'd1);
    start = 1; step(); start = 0;
    for (int i = 0; i < RSTC; i++) begin
      chk("restart.rst_n_low", 64'(core_rst_n), 64'd0);
      step();
    end
    chk("restart.run", 64'(state), 64'd2);

    // Ten retires then trap and stop together.
    for (int i = 0; i < 12; i++) begin
      retired = (i < 10); step();
    end
    retired = 0; trap = 1; tcause = 3'd5; stop = 1; step(); clear_in();
    chk("trap.status", 64'(status), 64'd1);
    chk("trap.cause",  64'(cause),  64'd5);
    chk("trap.retire", 64'(ret),    64'd10);

    // Timeout of 2000 RUN cycles.
    tmo = 16'd2000; start = 1; step(); start = 0; retired = 1;
    for (int i = 0; i < 2100 && m_state != 3; i++) step();
    chk("tmo.status", 64'(status), 64'd2);
    chk("tmo.cyc",    64'(cyc),    64'd2000);
    chk("tmo.clk_en", 64'(clk_en), 64'd0);
    retired = 0; stop = 1; trap = 1; step(); step(); clear_in();
    chk("tmo.hold", 64'(cyc), 64'd2000);

    // Upper timeout bits beyond CNT_W are ignored.
    tmo = 16'h1000 | 16'd7; start = 1; step(); start = 0; retired = 1;
    for (int i = 0; i < 30 && m_state != 3; i++) step();
    chk("tmohi.cyc", 64'(cyc), 64'd7);
    tmo = 0;

    // Saturation of both counters.
    start = 1; step(); start = 0; retired = 1;
    for (int i = 0; i < MAXC + 10; i++) step();
    chk("sat.cyc", 64'(cyc), 64'(MAXC));
    chk("sat.ret", 64'(ret), 64'(MAXC));
    stop = 1; step(); clear_in();

    // Stall watchdog: no retires, no timeout.
    start = 1; step(); start = 0;
    for (int i = 0; i < RSTC + 20; i++) step();
    chk("stall.state",  64'(state),  STALL_EN ? 64'd3 : 64'd2);
    chk("stall.status", 64'(status), STALL_EN ? 64'd4 : 64'd0);
    stop = 1; step(); clear_in();

    // Asynchronous reset mid-RUN.
    start = 1; step(); start = 0;
    for (int i = 0; i < RSTC; i++) step();
    retired = 1;
    for (int i = 0; i < 5; i++) step();
    retired = 0;
    #2 rst = 1;
    #1;
    model_reset();
    chk("arst.state", 64'(state),      64'd0);
    chk("arst.rst_n", 64'(core_rst_n), 64'd0);
    chk("arst.cyc",   64'(cyc),        64'd0);
    chk("arst.ret",   64'(ret),        64'd0);
    compare_all();
    @(posedge clk);
    #1 rst = 0;

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      start   = ($urandom_range(0, 19) == 0);
      stop    = ($urandom_range(0, 59) == 0);
      trap    = ($urandom_range(0, 79) == 0);
      tcause  = 3'($urandom_range(0, 7));
      retired = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 99) == 0) begin
        case ($urandom_range(0, 2))
          0:       tmo = 16'd0;
          1:       tmo = 16'($urandom_range(1, 60));
          default: tmo = 16'h1000 | 16'($urandom_range(1, 60));
        endcase
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
